instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 2: prefetch FIFO entries; power of two, >= 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
Ports:
REQ-003 The block SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req  out  1  fetch request valid.
REQ-006 The block SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-007 The block SHALL have port imem_gnt  in  1  request accepted when imem_req & imem_gnt.
REQ-008 The block SHALL have port imem_rvalid  in  1  response valid; in order, >= 1 cycle after grant.
REQ-009 The block SHALL have port imem_rdata  in  32  response instruction word.
REQ-010 The block SHALL have port redirect  in  1  taken branch/jump from the core, single-cycle pulse.
REQ-011 The block SHALL have port redirect_pc  in  32  redirect target.
REQ-012 The block SHALL have port instr_valid  out  1  instr_out/instr_pc valid to the core.
REQ-013 The block SHALL have port instr_out  out  32  instruction word to the decoder/control unit.
REQ-014 The block SHALL have port instr_pc  out  32  PC of instr_out.
REQ-015 The block SHALL have port instr_ready  in  1  core consumes when instr_valid & instr_ready.

Function
REQ-016 The FSM SHALL have states IDLE (one cycle after reset release), RUN, and FLUSH (discard_cnt > 0); IDLE->RUN unconditionally; RUN->FLUSH on redirect with responses outstanding; FLUSH->RUN when discard_cnt reaches 0.
REQ-017 imem_req SHALL be driven as (state != IDLE) & !redirect & (outstanding + fifo_count < DEPTH).
REQ-018 imem_addr SHALL equal fetch_pc; fetch_pc SHALL increment by 4 on each grant, wrapping 32'hFFFF_FFFC -> 0.
REQ-019 While imem_req is high without grant, imem_addr SHALL remain stable unless redirect is asserted.
REQ-020 Each non-discarded rvalid SHALL push {imem_rdata} into the FIFO; instr_valid SHALL rise the cycle after rvalid (latency 1, no bypass).
REQ-021 instr_pc SHALL start at RESET_PC, increment by 4 per pop, and load redirect_pc & ~3 on redirect.
REQ-022 instr_out/instr_pc SHALL hold stable while instr_valid & !instr_ready.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; the credit rule in REQ-017 SHALL guarantee no overflow, and no push SHALL ever be dropped when full.
REQ-024 On redirect, the FIFO SHALL be flushed (instr_valid low next cycle), fetch_pc SHALL load redirect_pc & ~3, and discard_cnt SHALL load outstanding minus (imem_rvalid ? 1 : 0).
REQ-025 Responses arriving while discard_cnt > 0 SHALL be dropped, decrementing discard_cnt; new requests MAY issue during FLUSH.
REQ-026 A pop coinciding with redirect SHALL count as consumed; a push coinciding with redirect SHALL be dropped.
REQ-027 A redirect during FLUSH SHALL add the new outstanding to discard_cnt (discard_cnt := total outstanding minus the current rvalid).

Reset
REQ-028 While rst is low: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=IDLE.
REQ-029 Reset asserted mid-operation SHALL abort all state immediately; the memory SHALL be reset by the same rst, so no stale responses arrive.
REQ-030 The first imem_req SHALL assert in the second cycle after rst deasserts.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=32, the fetch-state enum, and the RESET_PC default.
REQ-032 The FIFO SHALL be the sub-module fetch_fifo (DEPTH x 32, push/pop/flush, count output).

Verification
REQ-033 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addresses 0,4,8 issued; instr_valid with instr_pc 0,4,8 in order.
REQ-034 instr_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 grants, imem_req low, instr_out stable; then ready=1 -> fetching resumes at addr 8.
REQ-035 Redirect to 32'h0000_0103 with 2 outstanding -> next addr 32'h100, 2 responses dropped, first instr_pc 32'h100.
REQ-036 Redirect in the same cycle as rvalid and pop -> popped instruction counted, rvalid word dropped, discard_cnt = outstanding-1.
REQ-037 Redirect to 32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0 issued.
REQ-038 rst low mid-FLUSH -> all outputs at reset values within the same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice: data width, fetch FSM
// states and the default boot address.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched instruction words until the core consumes them.
// Head is read combinationally so a pushed word is visible the following cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [XLEN-1:0]            head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !flush && (count_reg != CW'(DEPTH));
    assign pop_ok  = pop && !flush && !empty;
    // An empty FIFO presents zero so the decoder never sees stale storage.
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches under a credit limit,
// buffers responses for the core and squashes in-flight fetches on redirect.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] instr_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_cnt_reg;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [XLEN-1:0] fifo_head;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   discard_next;
    logic [XLEN-1:0] redirect_target;
    logic            discarding;
    logic            grant;
    logic            pop;
    logic            push;

    assign discarding      = (discard_cnt_reg != '0);
    // Every in-flight request already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_used     = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign imem_req        = (state_reg != ST_IDLE) && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr       = fetch_pc_reg;
    assign grant           = imem_req && imem_gnt;
    assign pop             = instr_valid && instr_ready;
    assign push            = imem_rvalid && !redirect && !discarding;
    assign redirect_target = align_word(redirect_pc);
    // A response landing in the redirect cycle is dropped right away, so it is not counted again.
    assign discard_next    = outstanding_reg - CW'(imem_rvalid);

    assign instr_valid = !fifo_empty;
    assign instr_out   = fifo_head;
    assign instr_pc    = instr_pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            fetch_pc_reg    <= RESET_PC;
            instr_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_cnt_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(grant) - CW'(imem_rvalid);

            if (redirect) begin
                fetch_pc_reg    <= redirect_target;
                instr_pc_reg    <= redirect_target;
                discard_cnt_reg <= discard_next;
            end else begin
                if (grant) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (pop) begin
                    instr_pc_reg <= instr_pc_reg + 32'd4;
                end
                if (imem_rvalid && discarding) begin
                    discard_cnt_reg <= discard_cnt_reg - CW'(1);
                end
            end

            case (state_reg)
                ST_IDLE: state_reg <= ST_RUN;
                ST_RUN: begin
                    if (redirect && (discard_next != '0)) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        state_reg <= (discard_next != '0) ? ST_FLUSH : ST_RUN;
                    end else if (imem_rvalid && (discard_cnt_reg == CW'(1))) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(imem_rdata),
        .pop      (pop),
        .flush    (redirect),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule
